// File: rtl/wb_priority_arbiter.sv
// Write-back result arbiter: picks one of nine execution-unit results per cycle into a
// registered output slot, with a starvation guard that briefly reverses the priority order.
module wb_priority_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [9:0]           req_valid,
    output logic [9:0]           req_ready,
    input  logic [10*XLEN-1:0]   req_result,
    input  logic [49:0]          req_rd,
    input  logic [9:0]           req_fp_wr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [4:0]           out_rd,
    output logic                 out_fp_wr,
    output logic [3:0]           out_unit
);

    localparam logic [3:0] UNIT_NONE = 4'b0111;
    // Slot k (k=0 highest) holds the unit code: FDIV, FSQRT, R4, FMUL, FADD_SUB, DIV, MUL, FP, ALU.
    localparam logic [35:0] PRIO_ORDER = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd9, 4'd8, 4'd0};
    localparam logic [7:0]  STARVE_TC  = 8'(STARVE_LIMIT - 1);

    logic [7:0] starve_cnt;
    logic       inv_pending;
    logic       load;
    logic [9:0] valid_m;
    logic [9:0] grant;
    logic [3:0] win;
    logic [3:0] cand;
    logic       found;
    logic       losers;
    logic       xfer;

    always_comb begin
        load    = ~flush & (~out_valid | out_ready);
        valid_m = req_valid & ~10'b00_1000_0000;
        win     = UNIT_NONE;
        cand    = '0;
        found   = 1'b0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = 8; k >= 0; k--) begin
            cand = inv_pending ? PRIO_ORDER[4*(8-k) +: 4] : PRIO_ORDER[4*k +: 4];
            if (valid_m[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        grant = '0;
        if (load && found && reset_n)
            grant[win] = 1'b1;
        xfer   = |grant;
        losers = |(valid_m & ~grant);
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_fp_wr   <= 1'b0;
            out_unit    <= UNIT_NONE;
            starve_cnt  <= '0;
            inv_pending <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_unit    <= UNIT_NONE;
            starve_cnt  <= '0;
            inv_pending <= 1'b0;
        end else if (load) begin
            if (xfer) begin
                out_valid  <= 1'b1;
                out_unit   <= win;
                out_result <= req_result[int'(win)*XLEN +: XLEN];
                out_rd     <= req_rd[int'(win)*5 +: 5];
                out_fp_wr  <= req_fp_wr[win];
                if (inv_pending) begin
                    starve_cnt  <= '0;
                    inv_pending <= 1'b0;
                end else if (losers) begin
                    if (starve_cnt == STARVE_TC)
                        inv_pending <= 1'b1;
                    starve_cnt <= starve_cnt + 8'd1;
                end else begin
                    starve_cnt <= '0;
                end
            end else begin
                out_valid <= 1'b0;
                out_unit  <= UNIT_NONE;
            end
        end
    end

endmodule

// File: tb/tb_wb_priority_arbiter.sv
// Directed self-checking bench for wb_priority_arbiter (XLEN=32, STARVE_LIMIT=8).
module tb_wb_priority_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [9:0]        req_valid;
    logic [9:0]        req_ready;
    logic [10*XLEN-1:0] req_result;
    logic [49:0]       req_rd;
    logic [9:0]        req_fp_wr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [4:0]        out_rd;
    logic              out_fp_wr;
    logic [3:0]        out_unit;

    int n_chk  = 0;
    int n_pass = 0;

    wb_priority_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_result(req_result), .req_rd(req_rd), .req_fp_wr(req_fp_wr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_fp_wr(out_fp_wr),
        .out_unit(out_unit)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] res_of(input int u);
        return 32'hA500_0000 | 32'(u);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_payload();
        for (int i = 0; i < 10; i++) begin
            req_result[i*XLEN +: XLEN] = res_of(i);
            req_rd[i*5 +: 5]           = 5'(i + 3);
            req_fp_wr[i]               = (i % 2) == 1;
        end
    endtask

    // One cycle in which unit u is expected to win and be captured.
    task automatic step(input string tag, input int u);
        logic [9:0] exp_rdy;
        exp_rdy = 10'd1 << u;
        #1 chk({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk); #1;
        chk({tag, "_unit"}, 64'(out_unit), 64'(u));
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, 64'(out_result), 64'(res_of(u)));
        chk({tag, "_rd"}, 64'(out_rd), 64'(5'(u + 3)));
        chk({tag, "_fp"}, 64'(out_fp_wr), 64'((u % 2) == 1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_unit"}, 64'(out_unit), 64'd7);
        chk({tag, "_res"}, 64'(out_result), 64'd0);
        chk({tag, "_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_fp"}, 64'(out_fp_wr), 64'd0);
        chk({tag, "_rdy"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        req_valid = 10'b00_0100_0001;
        set_payload();
        #12;
        check_reset_values("rst");

        // First transfer on the first edge after release; FDIV beats ALU.
        @(negedge clk);
        reset_n = 1'b1;
        step("fdiv_first", 0);
        req_valid = 10'b00_0100_0000;
        step("alu_next", 6);

        // FSQRT outranks FMUL; unit 7 alone is never granted.
        req_valid = 10'b01_0000_0010;
        step("fsqrt", 8);
        req_valid = 10'b00_1000_0000;
        #1 chk("u7_rdy", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("u7_vld", 64'(out_valid), 64'd0);
        chk("u7_unit", 64'(out_unit), 64'd7);
        chk("idle_res_hold", 64'(out_result), 64'(res_of(8)));

        // Stall: output holds while out_ready is low, then FMUL transfers.
        req_valid = 10'b00_0100_0000;
        step("alu_load", 6);
        out_ready = 1'b0;
        req_valid = 10'b00_0000_0010;
        req_result[1*XLEN +: XLEN] = 32'hDEADBEEF;
        #1 chk("stall_rdy", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("stall_unit", 64'(out_unit), 64'd6);
        chk("stall_res", 64'(out_result), 64'(res_of(6)));
        chk("stall_vld", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1 chk("unstall_rdy", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        chk("unstall_res", 64'(out_result), 64'hDEADBEEF);
        chk("unstall_unit", 64'(out_unit), 64'd1);
        set_payload();

        // Starvation: 8 FDIV wins, one inverted ALU win, then FDIV again.
        req_valid = 10'b00_0100_0001;
        for (int i = 0; i < 10; i++)
            step($sformatf("starve%0d", i), (i == 8) ? 6 : 0);

        // Flush clears counter; then build counter to 5 and flush with output valid.
        flush = 1'b1;
        #1 chk("flush0_rdy", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 5; i++) step($sformatf("pre%0d", i), 0);
        flush = 1'b1;
        #1 chk("flush_rdy", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("flush_vld", 64'(out_valid), 64'd0);
        chk("flush_unit", 64'(out_unit), 64'd7);
        flush = 1'b0;

        // Counter restarted from 0: 8 FDIV, stall, inversion still pending.
        for (int i = 0; i < 8; i++) step($sformatf("post%0d", i), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("pend_stall_rdy", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            chk("pend_stall_unit", 64'(out_unit), 64'd0);
        end
        out_ready = 1'b1;
        step("pend_alu", 6);
        step("pend_fdiv", 0);

        // Flush discards a pending inversion.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) step($sformatf("arm%0d", i), 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        step("pend_cleared", 0);

        // Asynchronous reset mid-stream.
        step("pre_rst", 0);
        reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = 10'b00_0001_0000;
        step("post_rst", 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
